// File: rtl/csr_issue_fifo.sv
// First-word-fall-through FIFO carrying CSR-class issue packs to the CSR execute stage.
// Pointers carry an extra wrap bit so full and empty can be told apart without a counter.
package csr_issue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  rd_addr;
    logic [2:0]  funct3;
    logic [5:0]  rob_id;
  } issue_execute_pack_t;
endpackage

module csr_issue_fifo
  import csr_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  issue_execute_pack_t        issue_csr_fifo_data_in,
  input  logic                       issue_csr_fifo_push,
  output logic                       issue_csr_fifo_full,
  output logic [$clog2(DEPTH):0]     issue_csr_fifo_free_space,
  output issue_execute_pack_t        issue_csr_fifo_data_out,
  output logic                       issue_csr_fifo_data_out_valid,
  input  logic                       issue_csr_fifo_pop,
  input  logic                       issue_csr_fifo_flush
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  issue_execute_pack_t r_mem [DEPTH];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;

  logic [PW-1:0] w_wptr_next;
  logic [PW-1:0] w_rptr_next;
  logic [PW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_push_acc;
  logic          w_pop_acc;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_count = r_wptr - r_rptr;

  // Flush blocks both ports so a dropped push never lands in storage.
  assign w_push_acc = issue_csr_fifo_push && !w_full  && !issue_csr_fifo_flush;
  assign w_pop_acc  = issue_csr_fifo_pop  && !w_empty && !issue_csr_fifo_flush;

  always_comb begin
    w_wptr_next = r_wptr;
    w_rptr_next = r_rptr;
    if (issue_csr_fifo_flush) begin
      w_wptr_next = '0;
      w_rptr_next = '0;
    end else begin
      if (w_push_acc) w_wptr_next = r_wptr + PW'(1);
      if (w_pop_acc)  w_rptr_next = r_rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= w_wptr_next;
      r_rptr <= w_rptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_acc) begin
      r_mem[r_wptr[AW-1:0]] <= issue_csr_fifo_data_in;
    end
  end

  always_comb begin
    issue_csr_fifo_full           = w_full;
    issue_csr_fifo_free_space     = PW'(DEPTH) - w_count;
    issue_csr_fifo_data_out_valid = !w_empty;
    issue_csr_fifo_data_out       = r_mem[r_rptr[AW-1:0]];
  end

endmodule

// File: tb/tb_csr_issue_fifo.sv
// Scoreboard bench: stimulus queues expected packs, a negedge monitor checks every consumed head.
module tb_csr_issue_fifo;
  import csr_issue_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  issue_execute_pack_t data_in = '0;
  logic                push = 1'b0;
  logic                pop = 1'b0;
  logic                flush = 1'b0;
  logic                full;
  logic [2:0]          free_space;
  issue_execute_pack_t data_out;
  logic                valid;

  int n_checks = 0;
  int n_pass = 0;
  issue_execute_pack_t exp_q [$];

  csr_issue_fifo #(.DEPTH(4)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .issue_csr_fifo_data_in        (data_in),
    .issue_csr_fifo_push           (push),
    .issue_csr_fifo_full           (full),
    .issue_csr_fifo_free_space     (free_space),
    .issue_csr_fifo_data_out       (data_out),
    .issue_csr_fifo_data_out_valid (valid),
    .issue_csr_fifo_pop            (pop),
    .issue_csr_fifo_flush          (flush)
  );

  always #5 clk = ~clk;

  function automatic issue_execute_pack_t mk(input int rob);
    issue_execute_pack_t p;
    p.pc       = 32'h0000_1000 + 32'(rob) * 4;
    p.csr_addr = 12'h300 + 12'(rob);
    p.rs1_data = 32'hA5A5_0000 ^ 32'(rob * 97);
    p.rd_addr  = 5'(rob + 3);
    p.funct3   = 3'(rob);
    p.rob_id   = 6'(rob);
    return p;
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Drive one cycle of stimulus; accepted pushes feed the scoreboard.
  task automatic step(input bit p, input int rob, input bit po, input bit fl, input bit acc);
    @(posedge clk);
    #1;
    push    = p;
    data_in = p ? mk(rob) : '0;
    pop     = po;
    flush   = fl;
    if (fl) exp_q.delete();
    else if (p && acc) exp_q.push_back(mk(rob));
  endtask

  task automatic chk(input string name, input bit v, input bit f, input int fs,
                     input bit head_en, input int head_rob);
    @(negedge clk);
    check(valid == v, {name, " valid"}, int'(valid), int'(v));
    check(full == f, {name, " full"}, int'(full), int'(f));
    check(int'(free_space) == fs, {name, " free_space"}, int'(free_space), fs);
    if (head_en)
      check(data_out == mk(head_rob), {name, " head"}, int'(data_out.rob_id), head_rob);
  endtask

  // Monitor: every head the consumer actually takes must match the scoreboard front.
  always @(negedge clk) begin
    if (!rst && pop && !flush) begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "pop unexpected entry", int'(data_out.rob_id), -1);
        end else begin
          issue_execute_pack_t e;
          e = exp_q.pop_front();
          check(data_out == e, "pop data", int'(data_out.rob_id), int'(e.rob_id));
        end
      end else begin
        check(exp_q.size() == 0, "pop while empty", 0, exp_q.size());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(valid == 1'b0, "reset valid", int'(valid), 0);
    check(full == 1'b0, "reset full", int'(full), 0);
    check(int'(free_space) == 4, "reset free_space", int'(free_space), 4);
    check(data_out == '0, "reset data_out", int'(data_out.rob_id), 0);

    // Fill to full, overflow push is dropped, drain in order.
    for (int i = 1; i <= 4; i++) step(1, i, 0, 0, 1);
    step(1, 5, 0, 0, 0);
    chk("full after 4", 1, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    chk("overflow dropped", 1, 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("drained", 0, 0, 4, 0, 0);

    // Simultaneous push/pop at count 2.
    step(1, 7, 0, 0, 1);
    step(1, 8, 0, 0, 1);
    step(1, 9, 1, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("push+pop count2", 1, 0, 2, 1, 8);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("after 8,9", 0, 0, 4, 0, 0);

    // Stream 11 entries at low occupancy so pointers wrap twice.
    step(1, 40, 0, 0, 1);
    for (int i = 41; i <= 50; i++) step(1, i, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("after wrap stream", 0, 0, 4, 0, 0);

    // Flush with concurrent push and pop at count 3.
    step(1, 21, 0, 0, 1);
    step(1, 22, 0, 0, 1);
    step(1, 23, 0, 0, 1);
    step(1, 20, 1, 1, 0);
    chk("flush cycle old head", 1, 0, 1, 1, 21);
    step(0, 0, 0, 0, 0);
    chk("after flush", 0, 0, 4, 0, 0);
    step(1, 24, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("after post-flush pop", 0, 0, 4, 0, 0);

    // Pops on empty are ignored.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      chk("empty pop", 0, 0, 4, 0, 0);
    end
    step(1, 30, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("push after empty pops", 1, 0, 3, 1, 30);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("final empty", 0, 0, 4, 0, 0);

    check(exp_q.size() == 0, "scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_issue_fifo.md
# csr_issue_fifo

Single-clock, first-word-fall-through FIFO that buffers `issue_execute_pack_t` entries from the issue stage to the CSR execute stage. The issue stage pushes CSR-class instructions; the CSR execute stage sees the head entry combinationally and pops it when it hands the result to its writeback port. A commit-driven flush empties the queue in one cycle.

## Interface
- `DEPTH`, default 4: number of entries; power of two, at least 2.
- `clk`  input  1  clock.
- `rst`  input  1  synchronous, active-high reset.
- `issue_csr_fifo_data_in`  input  `issue_execute_pack_t`  entry to enqueue.
- `issue_csr_fifo_push`  input  1  enqueue request.
- `issue_csr_fifo_full`  output  1  no free entry.
- `issue_csr_fifo_free_space`  output  `$clog2(DEPTH)+1`  free entries (0..DEPTH).
- `issue_csr_fifo_data_out`  output  `issue_execute_pack_t`  head entry, fall-through.
- `issue_csr_fifo_data_out_valid`  output  1  head entry present (FIFO non-empty).
- `issue_csr_fifo_pop`  input  1  dequeue head.
- `issue_csr_fifo_flush`  input  1  discard all entries (driven from `commit_feedback_pack.enable && commit_feedback_pack.flush`).

## Operation
- Storage: `DEPTH` entries. Read and write pointers are `$clog2(DEPTH)+1` bits wide; the MSB is the wrap bit.
  - Empty when the pointers are fully equal.
  - Full when the low bits are equal and the MSBs differ.
- Count = `wptr - rptr`, computed modulo `2^(log2(DEPTH)+1)`.
- `free_space` = `DEPTH - count`.
- `data_out` = `storage[rptr[low]]`, combinational from registered state.
- `data_out_valid` = `!empty`.
- `full` and `free_space` are computed from registered pointers only. There is no combinational path from `push`/`pop` to any output.
- Push is accepted iff `push && !full && !flush`. An accepted push writes `storage[wptr[low]]` and does `wptr++`.
  - Push while full is ignored, even when a pop occurs in the same cycle. The issue stage must check `free_space`.
- Pop is accepted iff `pop && !empty && !flush`. An accepted pop does `rptr++`.
  - Pop while empty is ignored; pointers are unchanged.
- Simultaneous accepted push and pop: both pointers advance and count is unchanged.
  - When count is 1, the old head leaves and the new entry becomes the head on the next cycle.
- Flush has priority over push and pop in the same cycle: next `rptr = wptr = 0`, and the pushed entry is dropped.
- Reset has priority over everything: `rptr = wptr = 0` and all storage is cleared to 0.
- Pointer wrap: low bits wrap from `DEPTH-1` to 0 and the MSB toggles. FIFO order is preserved across the wrap.

## Timing
- Outputs after reset (the cycle following `rst` high):
  - `data_out_valid` = 0
  - `full` = 0
  - `free_space` = `DEPTH`
  - `data_out` = all-zero pack
- Push latency: an entry pushed at edge N appears on `data_out` with `data_out_valid` = 1 after edge N if the FIFO was empty.
- Pop: the head advances at the edge where pop is sampled. The next entry, or `valid` = 0, is visible in the following cycle.
- Flush: asserted in cycle N, so `data_out_valid` = 0 and `free_space` = `DEPTH` from cycle N+1.
  - In cycle N the consumer still sees the old head. The consumer must not pop while flushing; the pop is ignored regardless.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- Reset, then idle → `data_out_valid` = 0, `full` = 0, `free_space` = 4, `data_out` = 0.
- Push packs with rob_id 1,2,3,4 on consecutive cycles, then push rob_id 5 → after 4 pushes `full` = 1 and `free_space` = 0. rob_id 5 is dropped. Popping 4 times yields 1,2,3,4, then `valid` = 0.
- At count 2 (rob_id 7,8), push rob_id 9 and pop in the same cycle → count stays 2, head becomes 8, and the later order is 8,9.
- Push and pop 11 entries through the FIFO at count ≤ 2, so the pointers wrap twice → output order is strictly increasing rob_id with no loss or duplication.
- With count 3, assert flush together with push (rob_id 20) and pop → next cycle `valid` = 0 and `free_space` = 4. A subsequent pop of the next push returns only the newly pushed entry, never rob_id 20.
- Pop while empty for 3 cycles, then push rob_id 30 → `free_space` stays 4 during the empty pops, and rob_id 30 appears as head with `valid` = 1 the cycle after its push.
